// File: rtl/mesi_isc_pkg.sv
// -----------------------------------------------------------------------------
// mesi_isc_pkg
// Shared encodings for the MESI inter-snoop controller and its protocol
// monitor: main-bus and coherence-bus commands, broadcast request type,
// monitor error codes and the tracked-broadcast queue entry.
// No ports (package).
// -----------------------------------------------------------------------------
package mesi_isc_pkg;

    // Queue entries are sized for the widest supported configuration; the
    // monitor zero-extends narrower addresses/core indices into them.
    localparam int MON_ADDR_MAX = 64;
    localparam int MON_SRC_W    = 3;

    typedef enum logic [2:0] {
        MBUS_NOP      = 3'd0,
        MBUS_WR       = 3'd1,
        MBUS_RD       = 3'd2,
        MBUS_WR_BROAD = 3'd3,
        MBUS_RD_BROAD = 3'd4
    } mbus_cmd_e;

    typedef enum logic [2:0] {
        CBUS_NOP      = 3'd0,
        CBUS_WR_SNOOP = 3'd1,
        CBUS_RD_SNOOP = 3'd2,
        CBUS_EN_WR    = 3'd3,
        CBUS_EN_RD    = 3'd4
    } cbus_cmd_e;

    typedef enum logic {
        BREQ_WR = 1'b0,
        BREQ_RD = 1'b1
    } breq_type_e;

    typedef enum logic [2:0] {
        ERR_NONE          = 3'd0,
        ERR_TIMEOUT       = 3'd1,
        ERR_ADDR_MISMATCH = 3'd2,
        ERR_SNOOP_TO_SRC  = 3'd3,
        ERR_EARLY_EN      = 3'd4,
        ERR_QUEUE_OVF     = 3'd5,
        ERR_SPURIOUS      = 3'd6,
        ERR_WRONG_TYPE    = 3'd7
    } err_code_e;

    typedef struct packed {
        logic [MON_SRC_W-1:0]    src;
        breq_type_e              btype;
        logic [MON_ADDR_MAX-1:0] addr;
    } mon_entry_t;

    function automatic cbus_cmd_e snoop_for(breq_type_e t);
        return (t == BREQ_WR) ? CBUS_WR_SNOOP : CBUS_RD_SNOOP;
    endfunction

    function automatic cbus_cmd_e enable_for(breq_type_e t);
        return (t == BREQ_WR) ? CBUS_EN_WR : CBUS_EN_RD;
    endfunction

endpackage

// File: rtl/mesi_isc_mon_fifo.sv
// -----------------------------------------------------------------------------
// mesi_isc_mon_fifo
// Synchronous FIFO holding tracked broadcasts. Accepts up to NPUSH pushes per
// cycle, written in ascending port order; pushes that do not fit are dropped
// and flagged on drop_o. A pop in the same cycle frees its slot first.
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   push_i, data_i   per-port push request and entry
//   drop_o           per-port "push did not fit"
//   pop_i            remove head (ignored when empty)
//   head_o           current head entry (valid when !empty_o)
//   empty_o, full_o  occupancy flags
// -----------------------------------------------------------------------------
module mesi_isc_mon_fifo #(
    parameter int  DEPTH = 4,
    parameter int  NPUSH = 1,
    parameter type T     = logic
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NPUSH-1:0] push_i,
    input  T     [NPUSH-1:0] data_i,
    output logic [NPUSH-1:0] drop_o,
    input  logic             pop_i,
    output T                 head_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] cnt_q;

    logic             do_pop;
    logic [NPUSH-1:0] take;
    logic [CNT_W-1:0] slot [NPUSH];
    logic [CNT_W-1:0] n_take, space;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;

    // Lower ports claim free slots first.
    always_comb begin
        space  = CNT_W'(DEPTH) - cnt_q + CNT_W'(do_pop);
        n_take = '0;
        take   = '0;
        for (int i = 0; i < NPUSH; i++) begin
            slot[i] = n_take;
            if (push_i[i] && (n_take < space)) begin
                take[i] = 1'b1;
                n_take  = n_take + CNT_W'(1);
            end
        end
    end

    assign drop_o = push_i & ~take;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NPUSH; i++) begin
            if (take[i]) mem_q[wr_ptr_q + PTR_W'(slot[i])] <= data_i[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            wr_ptr_q <= wr_ptr_q + PTR_W'(n_take);
            cnt_q    <= cnt_q + n_take - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/mesi_isc_proto_mon.sv
// -----------------------------------------------------------------------------
// mesi_isc_proto_mon
// Protocol monitor for mesi_isc. Queues accepted main-bus broadcasts, then
// checks, for the queue head, that every non-source core receives a matching
// snoop (acked) before the source core receives the matching enable.
// Violations are reported as registered errors; the first code is sticky.
// Optional feature macro: MESI_ISC_MON_LAT_EN (head-latency tracking on
// max_lat_o; without it max_lat_o is tied to 0).
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   mbus_cmd_i/addr_i/ack_i           per-core main-bus command/address/ack
//   cbus_cmd_i/addr_i/ack_i           coherence-bus commands/address/acks
//   err_o                             one-cycle pulse per violating cycle
//   err_code_o, err_src_o             first error code / source core
//   busy_o                            broadcast queue non-empty
//   txn_cnt_o                         completed broadcasts (wrapping)
//   max_lat_o                         worst head latency (optional)
// -----------------------------------------------------------------------------
module mesi_isc_proto_mon
    import mesi_isc_pkg::*;
#(
    parameter int CORES   = 4,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3*CORES-1:0]         mbus_cmd_i,
    input  logic [ADDR_W*CORES-1:0]    mbus_addr_i,
    input  logic [CORES-1:0]           mbus_ack_i,
    input  logic [3*CORES-1:0]         cbus_cmd_i,
    input  logic [ADDR_W-1:0]          cbus_addr_i,
    input  logic [CORES-1:0]           cbus_ack_i,
    output logic                       err_o,
    output logic [2:0]                 err_code_o,
    output logic [$clog2(CORES)-1:0]   err_src_o,
    output logic                       busy_o,
    output logic [15:0]                txn_cnt_o,
    output logic [7:0]                 max_lat_o
);

    localparam int SRC_W = $clog2(CORES);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SNOOP, ST_ENABLE} state_e;

    state_e             state_q;
    logic [CORES-1:0]   ack_mask_q;
    logic [TMR_W-1:0]   tmr_q;
    logic [15:0]        txn_q;
    logic               err_q;
    logic [2:0]         err_code_q;
    logic [SRC_W-1:0]   err_src_q;

    // ---------------------------------------------------------------- accept
    mon_entry_t [CORES-1:0] push_data;
    logic [CORES-1:0]       push_vld, push_drop;
    mon_entry_t             head;
    logic                   q_empty, unused_q_full, pop;

    always_comb begin
        push_vld  = '0;
        push_data = '0;
        for (int c = 0; c < CORES; c++) begin
            push_vld[c] = mbus_ack_i[c] &&
                          (mbus_cmd_i[3*c +: 3] == MBUS_WR_BROAD ||
                           mbus_cmd_i[3*c +: 3] == MBUS_RD_BROAD);
            push_data[c].src   = MON_SRC_W'(c);
            push_data[c].btype = (mbus_cmd_i[3*c +: 3] == MBUS_RD_BROAD) ? BREQ_RD : BREQ_WR;
            push_data[c].addr  = MON_ADDR_MAX'(mbus_addr_i[ADDR_W*c +: ADDR_W]);
        end
    end

    // Overflow is reported per dropped port, so the full flag is not needed.
    mesi_isc_mon_fifo #(
        .DEPTH (DEPTH),
        .NPUSH (CORES),
        .T     (mon_entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_vld),
        .data_i  (push_data),
        .drop_o  (push_drop),
        .pop_i   (pop),
        .head_o  (head),
        .empty_o (q_empty),
        .full_o  (unused_q_full)
    );

    // ----------------------------------------------------------- head checks
    // IDLE with a non-empty queue behaves as the first SNOOP cycle (mask and
    // timer cleared), so a snoop is already checked one cycle after accept.
    logic               has_head, fresh, in_snoop, in_enable;
    logic [CORES-1:0]   mask_cur, mask_new, src_oh, snp_dlv;
    logic [TMR_W-1:0]   tmr_cur, tmr_nxt;
    logic               complete, en_dlv, tmo, any_err;
    cbus_cmd_e          snp_exp, en_exp;
    logic [2:0]         cb [CORES];
    logic [7:1]         flag;
    logic [SRC_W-1:0]   fsrc [1:7];
    logic [2:0]         code_sel;
    logic [SRC_W-1:0]   src_sel;

    always_comb begin
        has_head  = !q_empty;
        fresh     = (state_q == ST_IDLE);
        in_snoop  = has_head && (state_q != ST_ENABLE);
        in_enable = has_head && (state_q == ST_ENABLE);
        mask_cur  = fresh ? '0 : ack_mask_q;
        tmr_cur   = fresh ? '0 : tmr_q;
        tmr_nxt   = tmr_cur + TMR_W'(1);
        snp_exp   = snoop_for(head.btype);
        en_exp    = enable_for(head.btype);
        src_oh    = '0;
        snp_dlv   = '0;
        en_dlv    = 1'b0;
        for (int j = 0; j < CORES; j++) begin
            cb[j]     = cbus_cmd_i[3*j +: 3];
            src_oh[j] = (head.src == MON_SRC_W'(j));
            snp_dlv[j] = in_snoop && !src_oh[j] && (cb[j] == snp_exp) && cbus_ack_i[j];
        end
        // Acks of this cycle count before judging the enable.
        mask_new = mask_cur | snp_dlv;
        complete = &(mask_new | src_oh);
        for (int j = 0; j < CORES; j++) begin
            if ((in_enable || (in_snoop && complete)) && src_oh[j] &&
                (cb[j] == en_exp) && cbus_ack_i[j])
                en_dlv = 1'b1;
        end
        tmo = has_head && !en_dlv && (tmr_nxt == TMR_W'(TIMEOUT));
        pop = en_dlv || tmo;
    end

    // Error flags; within one code the lowest lane is reported.
    always_comb begin
        flag = '0;
        for (int k = 1; k < 8; k++) fsrc[k] = '0;
        if (tmo) begin
            flag[ERR_TIMEOUT] = 1'b1;
            fsrc[ERR_TIMEOUT] = head.src[SRC_W-1:0];
        end
        for (int j = 0; j < CORES; j++) begin
            if (push_drop[j] && !flag[ERR_QUEUE_OVF]) begin
                flag[ERR_QUEUE_OVF] = 1'b1;
                fsrc[ERR_QUEUE_OVF] = SRC_W'(j);
            end
            if (!has_head) begin
                if (cb[j] != CBUS_NOP && !flag[ERR_SPURIOUS]) begin
                    flag[ERR_SPURIOUS] = 1'b1;
                    fsrc[ERR_SPURIOUS] = SRC_W'(j);
                end
            end else if (cb[j] == CBUS_WR_SNOOP || cb[j] == CBUS_RD_SNOOP) begin
                if (src_oh[j]) begin
                    if (!flag[ERR_SNOOP_TO_SRC]) begin
                        flag[ERR_SNOOP_TO_SRC] = 1'b1;
                        fsrc[ERR_SNOOP_TO_SRC] = SRC_W'(j);
                    end
                end else begin
                    if (head.addr != MON_ADDR_MAX'(cbus_addr_i) && !flag[ERR_ADDR_MISMATCH]) begin
                        flag[ERR_ADDR_MISMATCH] = 1'b1;
                        fsrc[ERR_ADDR_MISMATCH] = SRC_W'(j);
                    end
                    if (cb[j] != snp_exp && !flag[ERR_WRONG_TYPE]) begin
                        flag[ERR_WRONG_TYPE] = 1'b1;
                        fsrc[ERR_WRONG_TYPE] = SRC_W'(j);
                    end
                end
            end else if ((cb[j] == CBUS_EN_WR || cb[j] == CBUS_EN_RD) && src_oh[j]) begin
                if (in_snoop && !complete && !flag[ERR_EARLY_EN]) begin
                    flag[ERR_EARLY_EN] = 1'b1;
                    fsrc[ERR_EARLY_EN] = SRC_W'(j);
                end
                if (cb[j] != en_exp && !flag[ERR_WRONG_TYPE]) begin
                    flag[ERR_WRONG_TYPE] = 1'b1;
                    fsrc[ERR_WRONG_TYPE] = SRC_W'(j);
                end
            end
        end
        // Lowest code wins.
        any_err  = |flag;
        code_sel = '0;
        src_sel  = '0;
        for (int k = 7; k >= 1; k--) begin
            if (flag[k]) begin
                code_sel = 3'(k);
                src_sel  = fsrc[k];
            end
        end
    end

    // ------------------------------------------------------------- head FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ack_mask_q <= '0;
            tmr_q      <= '0;
            txn_q      <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            err_src_q  <= '0;
        end else begin
            err_q <= any_err;
            if (any_err && err_code_q == ERR_NONE) begin
                err_code_q <= code_sel;
                err_src_q  <= src_sel;
            end
            if (en_dlv) txn_q <= txn_q + 16'd1;
            // After a pop, IDLE re-enters SNOOP at once if entries remain.
            if (!has_head || pop) begin
                state_q    <= ST_IDLE;
                ack_mask_q <= '0;
                tmr_q      <= '0;
            end else begin
                state_q    <= (in_enable || complete) ? ST_ENABLE : ST_SNOOP;
                ack_mask_q <= mask_new;
                tmr_q      <= tmr_nxt;
            end
        end
    end

    assign err_o      = err_q;
    assign err_code_o = err_code_q;
    assign err_src_o  = err_src_q;
    assign busy_o     = !q_empty;
    assign txn_cnt_o  = txn_q;

`ifdef MESI_ISC_MON_LAT_EN
    // Latency counts the SNOOP entry cycle as 1, up to the delivery cycle.
    logic [7:0] max_lat_q, lat_now;

    always_comb begin
        if (32'(tmr_nxt) > 32'd255) lat_now = 8'hFF;
        else                        lat_now = 8'(tmr_nxt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                max_lat_q <= '0;
        else if (en_dlv && lat_now > max_lat_q)  max_lat_q <= lat_now;
    end

    assign max_lat_o = max_lat_q;
`else
    assign max_lat_o = '0;
`endif

endmodule

// File: tb/tb_mesi_isc_proto_mon.sv
// -----------------------------------------------------------------------------
// tb_mesi_isc_proto_mon
// Directed bench for mesi_isc_proto_mon: normal broadcast, timeout, address
// mismatch, early enable, queue overflow, spurious command, multi-accept
// ordering and asynchronous reset mid-transaction.
// -----------------------------------------------------------------------------
module tb_mesi_isc_proto_mon;
    import mesi_isc_pkg::*;

    localparam int CORES   = 4;
    localparam int ADDR_W  = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 10;

`ifdef MESI_ISC_MON_LAT_EN
    localparam logic [7:0] EXP_LAT = 8'd2;
`else
    localparam logic [7:0] EXP_LAT = 8'd0;
`endif

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [3*CORES-1:0]      mbus_cmd_i;
    logic [ADDR_W*CORES-1:0] mbus_addr_i;
    logic [CORES-1:0]        mbus_ack_i;
    logic [3*CORES-1:0]      cbus_cmd_i;
    logic [ADDR_W-1:0]       cbus_addr_i;
    logic [CORES-1:0]        cbus_ack_i;
    logic                    err_o;
    logic [2:0]              err_code_o;
    logic [1:0]              err_src_o;
    logic                    busy_o;
    logic [15:0]             txn_cnt_o;
    logic [7:0]              max_lat_o;

    int n_cmp = 0;
    int n_err = 0;
    int err_pulses = 0;
    int pulse_base = 0;

    mesi_isc_proto_mon #(
        .CORES(CORES), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .mbus_cmd_i(mbus_cmd_i), .mbus_addr_i(mbus_addr_i), .mbus_ack_i(mbus_ack_i),
        .cbus_cmd_i(cbus_cmd_i), .cbus_addr_i(cbus_addr_i), .cbus_ack_i(cbus_ack_i),
        .err_o(err_o), .err_code_o(err_code_o), .err_src_o(err_src_o),
        .busy_o(busy_o), .txn_cnt_o(txn_cnt_o), .max_lat_o(max_lat_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (err_o) err_pulses++;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, limit 200000 time units");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        mbus_cmd_i  = '0;
        mbus_addr_i = '0;
        mbus_ack_i  = '0;
        cbus_cmd_i  = '0;
        cbus_addr_i = '0;
        cbus_ack_i  = '0;
    endtask

    task automatic set_mbus(input int c, input logic [2:0] cmd, input logic [31:0] addr);
        mbus_cmd_i[3*c +: 3]           = cmd;
        mbus_addr_i[ADDR_W*c +: ADDR_W] = addr;
        mbus_ack_i[c]                  = 1'b1;
    endtask

    task automatic set_cbus(input int c, input logic [2:0] cmd);
        cbus_cmd_i[3*c +: 3] = cmd;
        cbus_ack_i[c]        = 1'b1;
    endtask

    task automatic snoop_others(input int src, input logic [2:0] cmd, input logic [31:0] addr);
        for (int j = 0; j < CORES; j++) if (j != src) set_cbus(j, cmd);
        cbus_addr_i = addr;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        pulse_base = err_pulses;
    endtask

    // Write broadcast from core src: accept, snoops, enable (3 cycles).
    task automatic full_wr_txn(input int src, input logic [31:0] addr);
        set_mbus(src, MBUS_WR_BROAD, addr); tick(); idle_in();
        snoop_others(src, CBUS_WR_SNOOP, addr); tick(); idle_in();
        set_cbus(src, CBUS_EN_WR); tick(); idle_in();
    endtask

    initial begin
        idle_in();
        do_reset();
        tick();
        chk("rst_err",   err_o,      0);
        chk("rst_code",  err_code_o, 0);
        chk("rst_src",   err_src_o,  0);
        chk("rst_busy",  busy_o,     0);
        chk("rst_txn",   txn_cnt_o,  0);
        chk("rst_lat",   max_lat_o,  0);

        // Normal write broadcast from core 0.
        set_mbus(0, MBUS_WR_BROAD, 32'h100); tick(); idle_in();
        chk("t1_busy", busy_o, 1);
        snoop_others(0, CBUS_WR_SNOOP, 32'h100); tick(); idle_in();
        set_cbus(0, CBUS_EN_WR); tick(); idle_in();
        chk("t1_txn",   txn_cnt_o, 1);
        chk("t1_idle",  busy_o,    0);
        chk("t1_code",  err_code_o, 0);
        chk("t1_nopulse", err_pulses - pulse_base, 0);
        chk("t1_lat",   max_lat_o, EXP_LAT);

        // Core 3 never acks the snoop: timeout on the TIMEOUT-th head cycle.
        do_reset();
        set_mbus(2, MBUS_RD_BROAD, 32'h200); tick(); idle_in();
        set_cbus(0, CBUS_RD_SNOOP); set_cbus(1, CBUS_RD_SNOOP);
        cbus_addr_i = 32'h200; tick(); idle_in();
        repeat (TIMEOUT - 2) tick();
        chk("t2_pre_err", err_o, 0);
        tick();
        chk("t2_err",  err_o,      1);
        chk("t2_code", err_code_o, 1);
        chk("t2_src",  err_src_o,  2);
        chk("t2_busy", busy_o,     0);
        tick();
        chk("t2_pulse_end",  err_o,      0);
        chk("t2_code_stick", err_code_o, 1);

        // Snoop address differs from head address.
        do_reset();
        set_mbus(0, MBUS_WR_BROAD, 32'h100); tick(); idle_in();
        set_cbus(1, CBUS_WR_SNOOP); cbus_addr_i = 32'h104; tick(); idle_in();
        chk("t3_err",  err_o,      1);
        chk("t3_code", err_code_o, 2);
        chk("t3_src",  err_src_o,  1);

        // Enable before all acks, then the transaction completes.
        do_reset();
        set_mbus(0, MBUS_WR_BROAD, 32'h100); tick(); idle_in();
        set_cbus(1, CBUS_WR_SNOOP); cbus_addr_i = 32'h100;
        set_cbus(0, CBUS_EN_WR); tick(); idle_in();
        chk("t4_err",  err_o,      1);
        chk("t4_code", err_code_o, 4);
        chk("t4_src",  err_src_o,  0);
        set_cbus(2, CBUS_WR_SNOOP); set_cbus(3, CBUS_WR_SNOOP);
        cbus_addr_i = 32'h100; tick(); idle_in();
        set_cbus(0, CBUS_EN_WR); tick(); idle_in();
        chk("t4_txn",  txn_cnt_o,  1);
        chk("t4_busy", busy_o,     0);
        chk("t4_code_stick", err_code_o, 4);

        // DEPTH entries fill the queue; one more push overflows.
        do_reset();
        for (int c = 0; c < CORES; c++) set_mbus(c, MBUS_WR_BROAD, 32'h400 + 32'h40 * c);
        tick(); idle_in();
        chk("t5_fill_noerr", err_o,  0);
        chk("t5_fill_busy",  busy_o, 1);
        set_mbus(1, MBUS_RD_BROAD, 32'h500); tick(); idle_in();
        chk("t5_err",  err_o,      1);
        chk("t5_code", err_code_o, 5);
        chk("t5_src",  err_src_o,  1);

        // Coherence-bus command with nothing queued.
        do_reset();
        set_cbus(2, CBUS_WR_SNOOP); tick(); idle_in();
        chk("t6_err",  err_o,      1);
        chk("t6_code", err_code_o, 6);
        chk("t6_src",  err_src_o,  2);

        // Two accepts in one cycle are served lowest core first.
        do_reset();
        set_mbus(1, MBUS_WR_BROAD, 32'h300);
        set_mbus(3, MBUS_RD_BROAD, 32'h340); tick(); idle_in();
        snoop_others(1, CBUS_WR_SNOOP, 32'h300); tick(); idle_in();
        set_cbus(1, CBUS_EN_WR); tick(); idle_in();
        chk("t7_txn1",  txn_cnt_o, 1);
        chk("t7_busy1", busy_o,    1);
        snoop_others(3, CBUS_RD_SNOOP, 32'h340); tick(); idle_in();
        set_cbus(3, CBUS_EN_RD); tick(); idle_in();
        chk("t7_txn2",  txn_cnt_o, 2);
        chk("t7_busy2", busy_o,    0);
        chk("t7_code",  err_code_o, 0);
        chk("t7_nopulse", err_pulses - pulse_base, 0);

        // Reset asserted mid-SNOOP clears everything asynchronously.
        do_reset();
        full_wr_txn(0, 32'h100);
        set_mbus(2, MBUS_WR_BROAD, 32'h600); tick(); idle_in();
        set_cbus(1, CBUS_WR_SNOOP); cbus_addr_i = 32'h600; tick(); idle_in();
        chk("t8_pre_busy", busy_o,    1);
        chk("t8_pre_txn",  txn_cnt_o, 1);
        rst = 1'b0;
        #2;
        chk("t8_async_busy", busy_o,    0);
        chk("t8_async_txn",  txn_cnt_o, 0);
        chk("t8_async_err",  err_o,     0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        pulse_base = err_pulses;
        full_wr_txn(3, 32'h700);
        chk("t8_txn",     txn_cnt_o,  1);
        chk("t8_code",    err_code_o, 0);
        chk("t8_nopulse", err_pulses - pulse_base, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mesi_isc_proto_mon.md
# mesi_isc_proto_mon

Parametrised, synthesizable protocol monitor for the MESI inter-snoop controller (`mesi_isc`), bound alongside it and observing its main-bus and coherence-bus ports.
- Supports N cores and a configurable snoop-timeout window.
- Queues accepted broadcast requests.
- Checks per-transaction snoop and ack ordering, then the final enable.
- Reports violations as registered error outputs, usable in simulation, formal and silicon debug.

## Interface
- `CORES`, 4: number of cores, 2–8.
- `ADDR_W`, 32: address width.
- `DEPTH`, 4: tracked-broadcast queue depth, power of two.
- `TIMEOUT`, 10: maximum cycles an entry may remain at queue head.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `mbus_cmd_i` in 3*CORES: per-core main-bus command; core c at [3c+2:3c].
- `mbus_addr_i` in ADDR_W*CORES: per-core main-bus address.
- `mbus_ack_i` in CORES: observed ISC mbus acks.
- `cbus_cmd_i` in 3*CORES: observed ISC per-core cbus commands.
- `cbus_addr_i` in ADDR_W: observed ISC cbus address.
- `cbus_ack_i` in CORES: per-core cbus acks.
- `err_o` out 1: one-cycle pulse per detected violation.
- `err_code_o` out 3: first error code, sticky until reset.
- `err_src_o` out $clog2(CORES): source core of the first error.
- `busy_o` out 1: queue non-empty.
- `txn_cnt_o` out 16: completed broadcasts; wraps at 0xFFFF→0.
- `max_lat_o` out 8: worst observed head latency; see Configuration.

## Operation
Command encodings come from the shared package:
- mbus: NOP 0, WR 1, RD 2, WR_BROAD 3, RD_BROAD 4.
- cbus: NOP 0, WR_SNOOP 1, RD_SNOOP 2, EN_WR 3, EN_RD 4.

Accept and queue:
- A broadcast is accepted in a cycle where mbus_cmd of core c is WR_BROAD or RD_BROAD and `mbus_ack_i[c]`=1.
- On accept, {src c, type, addr} is pushed into the queue.
- If several cores are accepted in one cycle, they are pushed lowest index first.

Head FSM states: IDLE, SNOOP, ENABLE.
- IDLE → SNOOP when the queue is non-empty. On entry, clear `ack_mask` and the timer.
- SNOOP:
  - For each core j≠src, a snoop delivery is a cycle with cbus_cmd[j] equal to the matching snoop (WR_BROAD→WR_SNOOP, RD_BROAD→RD_SNOOP) and `cbus_ack_i[j]`=1. It sets `ack_mask[j]`.
  - When all non-src bits are set → ENABLE.
- ENABLE:
  - Delivery is cbus_cmd[src] equal to EN_WR or EN_RD (matching type) with `cbus_ack_i[src]`=1.
  - On delivery: pop, increment `txn_cnt`, return to IDLE.
  - If the queue is non-empty, go directly to SNOOP instead of IDLE.
- Timer: increments every cycle in SNOOP or ENABLE. Reaching TIMEOUT flags error 1, drops the head, and returns to IDLE.

Error codes:
- 1: TIMEOUT.
- 2: ADDR_MISMATCH — snoop cmd while `cbus_addr_i` ≠ head addr.
- 3: SNOOP_TO_SRC — snoop cmd on the src lane.
- 4: EARLY_EN — enable while in SNOOP.
- 5: QUEUE_OVF — push when full; the entry is dropped.
- 6: SPURIOUS — non-NOP cbus cmd while queue empty.
- 7: WRONG_TYPE — snoop or enable type differs from head type.

Error reporting:
- Several errors in one cycle: the lowest code wins.
- Errors 2/3/7 do not change FSM state.

## Timing
- All outputs are registered.
- Reset values: `err_o`=0, `err_code_o`=0, `err_src_o`=0, `busy_o`=0, `txn_cnt_o`=0, `max_lat_o`=0.
- Queue empty after reset.
- Push at accept edge; the entry is head-visible the next cycle. Earliest snoop check is accept+1.
- Simultaneous push and pop are allowed when the queue is full; no overflow in that case.
- `err_o` and `err_code_o` update one cycle after the offending cycle.
- `txn_cnt_o` increments one cycle after enable delivery.
- Snoop ack and enable in the same cycle: ack is recorded first. EARLY_EN fires only if ack_mask stays incomplete after that update.
- Reset asserted mid-transaction: all state is cleared asynchronously; no error is reported.

## Configuration
- `MESI_ISC_MON_LAT_EN` defined:
  - A head-latency counter (cycles from SNOOP entry to enable delivery) updates `max_lat_o` = max(`max_lat_o`, lat), saturating at 255.
- Undefined: `max_lat_o` is tied to 0 and no latency logic is built.

## Structure
- Package `mesi_isc_pkg`: mbus/cbus/breq encodings as typed enums, error-code enum, queue-entry struct {src, type, addr}.
- Sub-module `mesi_isc_mon_fifo`: parametrised synchronous FIFO (DEPTH, entry type) with full/empty, push/pop.
- FSM, masks and checks stay in the top module.

## Test plan
- Core 0 WR_BROAD at 0x100, acked → WR_SNOOP+ack on cores 1–3 at 0x100, then EN_WR+ack on core 0 → `txn_cnt_o`=1, `err_o` never pulses.
- Core 2 RD_BROAD accepted, core 3 never acks → `err_o` pulse with `err_code_o`=1 and `err_src_o`=2 at the TIMEOUT cycle; `busy_o`=0 afterwards.
- Snoop to core 1 with `cbus_addr_i`=0x104 while head addr is 0x100 → `err_code_o`=2.
- EN_WR to src before all acks → `err_code_o`=4; then the normal sequence completes and `txn_cnt_o`=1.
- DEPTH+1 broadcasts accepted with no cbus activity → `err_code_o`=5 on the final push.
- Reset asserted during SNOOP → all outputs 0; next full transaction counts 1 with no error.
